// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
//   Shared definitions for the RV32I in-order core. Decode and execute both
//   import this package so that the one-hot opcode and ALU-operation vectors
//   have the same bit meaning on both sides of the pipeline register.
//
//   Contents:
//     - 7-bit major opcode constants (instr[6:0])
//     - bit-index enums for the o_opcode and o_alu_op one-hot vectors
//     - widths of those one-hot vectors
//     - instr[31:20] codes that identify the privileged SYSTEM instructions
// ---------------------------------------------------------------------------
package core_pkg;

  localparam int OPCODE_W = 11;
  localparam int ALU_OP_W = 14;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Bit positions inside the o_opcode one-hot vector (bit 0 = LUI).
  typedef enum logic [3:0] {
    OP_IDX_LUI    = 4'd0,
    OP_IDX_AUIPC  = 4'd1,
    OP_IDX_JAL    = 4'd2,
    OP_IDX_JALR   = 4'd3,
    OP_IDX_BRANCH = 4'd4,
    OP_IDX_LOAD   = 4'd5,
    OP_IDX_STORE  = 4'd6,
    OP_IDX_OP_IMM = 4'd7,
    OP_IDX_OP     = 4'd8,
    OP_IDX_FENCE  = 4'd9,
    OP_IDX_SYSTEM = 4'd10
  } opcode_idx_e;

  // Bit positions inside the o_alu_op one-hot vector (bit 0 = ADD).
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_AND  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_EQ   = 4'd10,
    ALU_NEQ  = 4'd11,
    ALU_GE   = 4'd12,
    ALU_GEU  = 4'd13
  } alu_idx_e;

  localparam logic [11:0] SYS_ECALL  = 12'h000;
  localparam logic [11:0] SYS_EBREAK = 12'h001;
  localparam logic [11:0] SYS_MRET   = 12'h302;
  localparam logic [11:0] SYS_WFI    = 12'h105;

endpackage

// File: rtl/decode_imm_gen.sv
// ---------------------------------------------------------------------------
// imm_gen
//   Purely combinational immediate extractor for the decode stage. Picks the
//   I/S/B/U/J format from the major opcode and sign-extends from instr[31].
//   FENCE, OP and any unrecognised or compressed encoding produce 0.
//
//   Ports:
//     i_instr  in  32  instruction word
//     o_imm    out 32  sign-extended immediate
// ---------------------------------------------------------------------------
module imm_gen
  import core_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [31:0] o_imm
);

  // Format selection by major opcode. B and J immediates are halfword
  // offsets, so their bit 0 is always zero.
  always_comb begin
    o_imm = 32'd0;
    case (i_instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM:
        o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      OPC_STORE:
        o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      OPC_BRANCH:
        o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                 i_instr[30:25], i_instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        o_imm = {i_instr[31:12], 12'd0};
      OPC_JAL:
        o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                 i_instr[20], i_instr[30:21], 1'b0};
      default:
        o_imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/decode.sv
// ---------------------------------------------------------------------------
// decode
//   Second stage of the RV32I in-order pipeline. Captures the instruction and
//   PC from fetch whenever fetch's clock enable is high and the pipeline is
//   not stalled, and registers the decoded fields for execute. The execute
//   clock enable (clk_en) follows fetch's enable one cycle later, is frozen
//   by stall, and is cleared by flush.
//
//   Optional feature macro: DECODE_ILLEGAL_CHK_EN
//     defined   -> o_illegal is a registered illegal-instruction flag
//     undefined -> o_illegal is tied to 0
//
//   Ports:
//     clk, rst                 clock, async active-high reset
//     i_instr, i_pc, i_ce      instruction, PC and enable from fetch
//     stall, flush             pipeline control
//     o_pc                     registered PC
//     o_rs1_addr, o_rs2_addr   source register addresses
//     o_rd_addr, o_rd_wr       destination address (0 when not written)
//     o_imm                    sign-extended immediate
//     o_funct3                 instr[14:12]
//     o_opcode                 11-bit one-hot major opcode
//     o_alu_op                 14-bit one-hot ALU operation
//     o_ecall, o_ebreak,
//     o_mret, o_wfi            system instruction flags
//     o_illegal                illegal-instruction flag
//     clk_en                   clock enable for execute
// ---------------------------------------------------------------------------
module decode
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic        i_ce,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] o_pc,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  output logic [4:0]  o_rd_addr,
  output logic        o_rd_wr,
  output logic [31:0] o_imm,
  output logic [2:0]  o_funct3,
  output logic [10:0] o_opcode,
  output logic [13:0] o_alu_op,
  output logic        o_ecall,
  output logic        o_ebreak,
  output logic        o_mret,
  output logic        o_wfi,
  output logic        o_illegal,
  output logic        clk_en
);

  logic [6:0]  w_opc;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic        w_upd;
  logic [31:0] w_imm;
  logic [10:0] w_opcodeOh;
  logic [13:0] w_aluOh;
  logic        w_rdWr;
  logic [4:0]  w_rdAddr;
  logic        w_sysBase;
  logic        w_ecall;
  logic        w_ebreak;
  logic        w_mret;
  logic        w_wfi;

  logic [31:0] r_pc;
  logic [4:0]  r_rs1Addr;
  logic [4:0]  r_rs2Addr;
  logic [4:0]  r_rdAddr;
  logic        r_rdWr;
  logic [31:0] r_imm;
  logic [2:0]  r_funct3;
  logic [10:0] r_opcode;
  logic [13:0] r_aluOp;
  logic        r_ecall;
  logic        r_ebreak;
  logic        r_mret;
  logic        r_wfi;
  logic        r_clkEn;

  assign w_opc    = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_rs1    = i_instr[19:15];
  assign w_rs2    = i_instr[24:20];
  assign w_rd     = i_instr[11:7];
  assign w_upd    = i_ce & ~stall;

  imm_gen u_immGen (
    .i_instr (i_instr),
    .o_imm   (w_imm)
  );

  // Major opcode to one-hot. All RV32I opcodes end in 2'b11, so a compressed
  // encoding never matches and leaves the vector all-zero.
  always_comb begin
    w_opcodeOh = '0;
    case (w_opc)
      OPC_LUI:    w_opcodeOh[OP_IDX_LUI]    = 1'b1;
      OPC_AUIPC:  w_opcodeOh[OP_IDX_AUIPC]  = 1'b1;
      OPC_JAL:    w_opcodeOh[OP_IDX_JAL]    = 1'b1;
      OPC_JALR:   w_opcodeOh[OP_IDX_JALR]   = 1'b1;
      OPC_BRANCH: w_opcodeOh[OP_IDX_BRANCH] = 1'b1;
      OPC_LOAD:   w_opcodeOh[OP_IDX_LOAD]   = 1'b1;
      OPC_STORE:  w_opcodeOh[OP_IDX_STORE]  = 1'b1;
      OPC_OP_IMM: w_opcodeOh[OP_IDX_OP_IMM] = 1'b1;
      OPC_OP:     w_opcodeOh[OP_IDX_OP]     = 1'b1;
      OPC_FENCE:  w_opcodeOh[OP_IDX_FENCE]  = 1'b1;
      OPC_SYSTEM: w_opcodeOh[OP_IDX_SYSTEM] = 1'b1;
      default:    w_opcodeOh = '0;
    endcase
  end

  // ALU operation select. instr[30] is funct7[5]; it only selects SUB for
  // register-register OP, because in OP_IMM with funct3 = 000 it is just an
  // immediate bit. Both OP and OP_IMM use it to pick SRA over SRL. Branch
  // funct3 codes 010/011 are undefined and fall back to ADD.
  always_comb begin
    w_aluOh = '0;
    if (w_opcodeOh[OP_IDX_OP] || w_opcodeOh[OP_IDX_OP_IMM]) begin
      case (w_funct3)
        3'b000: begin
          if (w_opcodeOh[OP_IDX_OP] && i_instr[30]) w_aluOh[ALU_SUB] = 1'b1;
          else                                       w_aluOh[ALU_ADD] = 1'b1;
        end
        3'b001: w_aluOh[ALU_SLL]  = 1'b1;
        3'b010: w_aluOh[ALU_SLT]  = 1'b1;
        3'b011: w_aluOh[ALU_SLTU] = 1'b1;
        3'b100: w_aluOh[ALU_XOR]  = 1'b1;
        3'b101: begin
          if (i_instr[30]) w_aluOh[ALU_SRA] = 1'b1;
          else             w_aluOh[ALU_SRL] = 1'b1;
        end
        3'b110: w_aluOh[ALU_OR]   = 1'b1;
        default: w_aluOh[ALU_AND] = 1'b1;
      endcase
    end else if (w_opcodeOh[OP_IDX_BRANCH]) begin
      case (w_funct3)
        3'b000:  w_aluOh[ALU_EQ]   = 1'b1;
        3'b001:  w_aluOh[ALU_NEQ]  = 1'b1;
        3'b100:  w_aluOh[ALU_SLT]  = 1'b1;
        3'b101:  w_aluOh[ALU_GE]   = 1'b1;
        3'b110:  w_aluOh[ALU_SLTU] = 1'b1;
        3'b111:  w_aluOh[ALU_GEU]  = 1'b1;
        default: w_aluOh[ALU_ADD]  = 1'b1;
      endcase
    end else begin
      w_aluOh[ALU_ADD] = 1'b1;
    end
  end

  // Writes to x0 are dropped here so execute never has to special-case it;
  // the address is zeroed too so forwarding logic sees a clean 0.
  assign w_rdWr = (w_rd != 5'd0) &&
                  !(w_opcodeOh[OP_IDX_BRANCH] || w_opcodeOh[OP_IDX_STORE] ||
                    w_opcodeOh[OP_IDX_FENCE]  ||
                    (w_opcodeOh[OP_IDX_SYSTEM] && (w_funct3 == 3'b000)));
  assign w_rdAddr = w_rdWr ? w_rd : 5'd0;

  assign w_sysBase = w_opcodeOh[OP_IDX_SYSTEM] && (w_funct3 == 3'b000) &&
                     (w_rs1 == 5'd0) && (w_rd == 5'd0);
  assign w_ecall  = w_sysBase && (i_instr[31:20] == SYS_ECALL);
  assign w_ebreak = w_sysBase && (i_instr[31:20] == SYS_EBREAK);
  assign w_mret   = w_sysBase && (i_instr[31:20] == SYS_MRET);
  assign w_wfi    = w_sysBase && (i_instr[31:20] == SYS_WFI);

  // Pipeline register. Data loads only when fetch presents a valid word and
  // the pipe is moving. clk_en is frozen by stall (so a flush during a stall
  // is ignored), cleared by flush, and otherwise follows fetch's enable,
  // which turns an i_ce gap into a bubble for execute.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= 32'd0;
      r_rs1Addr <= 5'd0;
      r_rs2Addr <= 5'd0;
      r_rdAddr  <= 5'd0;
      r_rdWr    <= 1'b0;
      r_imm     <= 32'd0;
      r_funct3  <= 3'd0;
      r_opcode  <= '0;
      r_aluOp   <= '0;
      r_ecall   <= 1'b0;
      r_ebreak  <= 1'b0;
      r_mret    <= 1'b0;
      r_wfi     <= 1'b0;
      r_clkEn   <= 1'b0;
    end else begin
      if (w_upd) begin
        r_pc      <= i_pc;
        r_rs1Addr <= w_rs1;
        r_rs2Addr <= w_rs2;
        r_rdAddr  <= w_rdAddr;
        r_rdWr    <= w_rdWr;
        r_imm     <= w_imm;
        r_funct3  <= w_funct3;
        r_opcode  <= w_opcodeOh;
        r_aluOp   <= w_aluOh;
        r_ecall   <= w_ecall;
        r_ebreak  <= w_ebreak;
        r_mret    <= w_mret;
        r_wfi     <= w_wfi;
      end
      if (!stall) begin
        r_clkEn <= flush ? 1'b0 : i_ce;
      end
    end
  end

`ifdef DECODE_ILLEGAL_CHK_EN
  logic [6:0] w_funct7;
  logic       w_illegal;
  logic       r_illegal;

  assign w_funct7 = i_instr[31:25];

  // Illegal when the opcode is unknown (including compressed words), a
  // funct3/funct7 is undefined for its class, a SYSTEM funct3=000 word is
  // not one of the four recognised privileged instructions, or the word is
  // all-zero / all-one (typical of uninitialised memory).
  assign w_illegal =
      (w_opcodeOh == '0) ||
      (w_opcodeOh[OP_IDX_BRANCH] && ((w_funct3 == 3'b010) || (w_funct3 == 3'b011))) ||
      (w_opcodeOh[OP_IDX_LOAD] && ((w_funct3 == 3'b011) || (w_funct3 == 3'b110) ||
                                   (w_funct3 == 3'b111))) ||
      (w_opcodeOh[OP_IDX_STORE] && (w_funct3 >= 3'b011)) ||
      (w_opcodeOh[OP_IDX_OP] && (w_funct7 != 7'h00) && (w_funct7 != 7'h20)) ||
      (w_opcodeOh[OP_IDX_SYSTEM] && (w_funct3 == 3'b000) &&
       !(w_ecall || w_ebreak || w_mret || w_wfi)) ||
      (i_instr == 32'h0000_0000) ||
      (i_instr == 32'hFFFF_FFFF);

  // The illegal flag travels with the rest of the decoded fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_illegal <= 1'b0;
    end else if (w_upd) begin
      r_illegal <= w_illegal;
    end
  end

  assign o_illegal = r_illegal;
`else
  assign o_illegal = 1'b0;
`endif

  assign o_pc       = r_pc;
  assign o_rs1_addr = r_rs1Addr;
  assign o_rs2_addr = r_rs2Addr;
  assign o_rd_addr  = r_rdAddr;
  assign o_rd_wr    = r_rdWr;
  assign o_imm      = r_imm;
  assign o_funct3   = r_funct3;
  assign o_opcode   = r_opcode;
  assign o_alu_op   = r_aluOp;
  assign o_ecall    = r_ecall;
  assign o_ebreak   = r_ebreak;
  assign o_mret     = r_mret;
  assign o_wfi      = r_wfi;
  assign clk_en     = r_clkEn;

endmodule
